// File: rtl/word_8bit_if.sv
// Bus bundle for one RAM word: write data, select, read/write and read data.
interface word_8bit_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             sel;
    logic             rw;
    logic [WIDTH-1:0] data_out;

    modport master (
        output data_in,
        output sel,
        output rw,
        input  data_out
    );

    modport slave (
        input  data_in,
        input  sel,
        input  rw,
        output data_out
    );
endinterface

// File: rtl/word_8bit.sv
// One addressable RAM word: WIDTH bit cells with shared select and rw control.
// Unselected or writing rows drive zeros so rows can be OR-combined upstream.
module word_8bit #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    word_8bit_if.slave  bus
);
    logic [WIDTH-1:0] mem;
    logic             wr_en;
    logic             rd_en;

    assign wr_en = bus.sel & bus.rw;
    assign rd_en = bus.sel & ~bus.rw;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem <= '0;
        end else if (wr_en) begin
            mem <= bus.data_in;
        end
    end

    // No write bypass: a writing row reads as zero.
    assign bus.data_out = rd_en ? mem : '0;
endmodule

// File: tb/tb_word_8bit.sv
// Directed bench for word_8bit: reset, write/read, hold, reset priority,
// output gating and back-to-back writes.
module tb_word_8bit;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    word_8bit_if #(.WIDTH(8)) bus ();

    word_8bit #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic drive(input logic s, input logic r,
                         input logic [7:0] d);
        bus.sel     = s;
        bus.rw      = r;
        bus.data_in = d;
        #1;
    endtask

    task automatic edge_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        bus.sel     = 1'b0;
        bus.rw      = 1'b0;
        bus.data_in = 8'h00;
        @(negedge clk);
        edge_step();
        rst_n = 1'b1;

        drive(1'b1, 1'b0, 8'hxx);
        check("reset_read", bus.data_out, 8'b00000000);

        drive(1'b1, 1'b1, 8'b01010101);
        check("write_gated", bus.data_out, 8'h00);
        edge_step();
        drive(1'b1, 1'b0, 8'hxx);
        check("read_55", bus.data_out, 8'b01010101);

        drive(1'b1, 1'b1, 8'b10100000);
        edge_step();
        drive(1'b1, 1'b0, 8'hxx);
        check("overwrite", bus.data_out, 8'b10100000);

        drive(1'b0, 1'b1, 8'hxx);
        check("unsel_wr_zero", bus.data_out, 8'h00);
        edge_step();
        check("unsel_after", bus.data_out, 8'h00);
        drive(1'b1, 1'b0, 8'hxx);
        check("hold_read", bus.data_out, 8'b10100000);

        drive(1'b1, 1'b0, 8'h3C);
        edge_step();
        check("read_no_write", bus.data_out, 8'b10100000);

        rst_n = 1'b0;
        drive(1'b1, 1'b1, 8'hFF);
        edge_step();
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 8'hxx);
        check("reset_priority", bus.data_out, 8'h00);

        drive(1'b1, 1'b1, 8'hA5);
        edge_step();
        drive(1'b1, 1'b1, 8'hA5);
        check("gate_write", bus.data_out, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        check("gate_unsel_rd", bus.data_out, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        check("gate_read", bus.data_out, 8'hA5);

        drive(1'b1, 1'b1, 8'h11);
        edge_step();
        drive(1'b1, 1'b1, 8'h22);
        edge_step();
        drive(1'b1, 1'b1, 8'hC3);
        edge_step();
        drive(1'b1, 1'b0, 8'h00);
        check("b2b_last_wins", bus.data_out, 8'hC3);

        // Mid-cycle glitch on rw; only the edge-time value may matter.
        bus.data_in = 8'h7E;
        bus.rw      = 1'b1;
        #1;
        check("glitch_gated", bus.data_out, 8'h00);
        bus.rw = 1'b0;
        #1;
        edge_step();
        check("glitch_no_wr", bus.data_out, 8'hC3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
